alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-entry issue stage in front of a combinational ALU: registers operands, waits one
// settling cycle, captures the flags. Optional overflow counter: define ALU_ISSUE_OVFCNT_EN.
module alu_issue #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [2:0]   req_op,
  input  logic [3:0]   req_tag,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_ctr,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_overflow,
  output logic [3:0]   rsp_tag
`ifdef ALU_ISSUE_OVFCNT_EN
  ,
  output logic [7:0]   ovf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q, state_d;
  logic         accept, capture;
  logic [N-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [2:0]   alu_ctr_q;
  logic [3:0]   tag_q, rsp_tag_q;
  logic         rsp_zero_q, rsp_overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    accept    = (state_q == IDLE) && req_valid;
    capture   = (state_q == EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctr_q      <= '0;
      tag_q          <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      if (accept) begin
        alu_a_q   <= req_a;
        alu_b_q   <= req_b;
        alu_ctr_q <= req_op;
        tag_q     <= req_tag;
      end
      if (capture) begin
        rsp_result_q   <= alu_result;
        rsp_zero_q     <= alu_zero;
        rsp_overflow_q <= alu_overflow;
        rsp_tag_q      <= tag_q;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctr      = alu_ctr_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_tag      = rsp_tag_q;

`ifdef ALU_ISSUE_OVFCNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if ((state_q == RESP) && rsp_ready && rsp_overflow_q && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
